key_debounce: RTL and testbench

//  Input-side counterpart to the LED outputs: conditions the board's active-low pushbuttons for PL logic.
//  Per key: 2-FF synchroniser, debounce FSM, registered level output and one-cycle press/release/long-press pulses.

---
 rtl/key_debounce.sv | 153 +++++++++++++++
 tb/tb_key_debounce.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Pushbutton conditioner: per-key 2-FF synchroniser, debounce FSM,
// registered level plus press/release/long-press pulses.
module key_debounce #(
    parameter int N_KEYS      = 4,
    parameter int CLOCK_FREQ  = 50000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_KEYS-1:0] KEY_N,
    output logic [N_KEYS-1:0] KEY_STATE,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic [N_KEYS-1:0] KEY_LONG
);

    localparam int D  = CLOCK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int L  = CLOCK_FREQ / 1000 * LONG_MS;
    localparam int CW = $clog2(L + 1);

    localparam logic [CW-1:0] D_M1 = CW'(D - 1);
    localparam logic [CW-1:0] L_M1 = CW'(L - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        UP,
        FILT_DN,
        DOWN,
        HELD,
        FILT_UP
    } state_t;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~KEY_N;
            sync2 <= sync1;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        state_t        st_q, st_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          lng_q, lng_d;
        logic          lvl_q, lvl_d;
        logic          prs_q, prs_d;
        logic          rel_q, rel_d;
        logic          lp_q, lp_d;
        logic          s;

        assign s = sync2[k];

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                st_q  <= UP;
                cnt_q <= '0;
                lng_q <= 1'b0;
                lvl_q <= 1'b0;
                prs_q <= 1'b0;
                rel_q <= 1'b0;
                lp_q  <= 1'b0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                lng_q <= lng_d;
                lvl_q <= lvl_d;
                prs_q <= prs_d;
                rel_q <= rel_d;
                lp_q  <= lp_d;
            end
        end

        // lng_q remembers whether the long pulse fired for this press,
        // so a release bounce returns to HELD instead of re-arming.
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            lng_d = lng_q;
            lvl_d = lvl_q;
            prs_d = 1'b0;
            rel_d = 1'b0;
            lp_d  = 1'b0;
            unique case (st_q)
                UP: begin
                    if (s) begin
                        st_d  = FILT_DN;
                        cnt_d = '0;
                    end
                end
                FILT_DN: begin
                    if (!s) begin
                        st_d = UP;
                    end else if (cnt_q == D_M1) begin
                        st_d  = DOWN;
                        cnt_d = '0;
                        lng_d = 1'b0;
                        lvl_d = 1'b1;
                        prs_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                DOWN: begin
                    if (!s) begin
                        st_d  = FILT_UP;
                        cnt_d = '0;
                    end else if (cnt_q == L_M1) begin
                        st_d  = HELD;
                        lng_d = 1'b1;
                        lp_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                HELD: begin
                    if (!s) begin
                        st_d  = FILT_UP;
                        cnt_d = '0;
                    end
                end
                FILT_UP: begin
                    if (s) begin
                        st_d  = lng_q ? HELD : DOWN;
                        cnt_d = '0;
                    end else if (cnt_q == D_M1) begin
                        st_d  = UP;
                        cnt_d = '0;
                        lvl_d = 1'b0;
                        rel_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    st_d  = UP;
                    cnt_d = '0;
                end
            endcase
        end

        assign KEY_STATE[k]   = lvl_q;
        assign KEY_PRESS[k]   = prs_q;
        assign KEY_RELEASE[k] = rel_q;
        assign KEY_LONG[k]    = lp_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a cycle-stamped scoreboard
// of expected pulses checked on every falling edge.
module tb_key_debounce;

    logic       CLK;
    logic       RST_N;
    logic [3:0] KEY_N;
    logic [3:0] KEY_STATE;
    logic [3:0] KEY_PRESS;
    logic [3:0] KEY_RELEASE;
    logic [3:0] KEY_LONG;

    key_debounce #(
        .N_KEYS     (4),
        .CLOCK_FREQ (1000),
        .DEBOUNCE_MS(4),
        .LONG_MS    (20)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .KEY_N      (KEY_N),
        .KEY_STATE  (KEY_STATE),
        .KEY_PRESS  (KEY_PRESS),
        .KEY_RELEASE(KEY_RELEASE),
        .KEY_LONG   (KEY_LONG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] lng;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   nchk = 0;
    int   npass = 0;
    int   nfail = 0;

    logic [3:0] exp_state = '0;
    logic [3:0] ep, er, el;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void push(int c, logic [3:0] p, logic [3:0] r, logic [3:0] l);
        exp_t e;
        e.cyc = c;
        e.prs = p;
        e.rel = r;
        e.lng = l;
        q.push_back(e);
    endfunction

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Every cycle: pulses must equal the scheduled ones (zero otherwise).
    always @(negedge CLK) begin
        ep = '0;
        er = '0;
        el = '0;
        if (!RST_N) begin
            exp_state = '0;
        end else begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc == cyc) begin
                    ep |= q[i].prs;
                    er |= q[i].rel;
                    el |= q[i].lng;
                    q.delete(i);
                end
            end
            exp_state = (exp_state | ep) & ~er;
        end
        chk("press", KEY_PRESS, ep);
        chk("release", KEY_RELEASE, er);
        chk("long", KEY_LONG, el);
        chk("state", KEY_STATE, exp_state);
    end

    task automatic idle(int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int c;
        RST_N = 1'b0;
        KEY_N = 4'b0000;
        idle(4);

        // all keys held through reset
        RST_N = 1'b1;
        push(cyc + 7, 4'b1111, 4'b0000, 4'b0000);
        idle(10);
        KEY_N = 4'b1111;
        push(cyc + 7, 4'b0000, 4'b1111, 4'b0000);
        idle(12);

        // clean long hold on key0
        KEY_N[0] = 1'b0;
        c = cyc;
        push(c + 7, 4'b0001, 4'b0000, 4'b0000);
        push(c + 27, 4'b0000, 4'b0000, 4'b0001);
        idle(30);
        KEY_N[0] = 1'b1;
        push(cyc + 7, 4'b0000, 4'b0001, 4'b0000);
        idle(12);

        // key1 bouncing: nothing accepted
        for (int i = 0; i < 5; i++) begin
            KEY_N[1] = 1'b0;
            idle(2);
            KEY_N[1] = 1'b1;
            idle(2);
        end
        idle(10);

        // key2 bounce then settle
        KEY_N[2] = 1'b0;
        idle(3);
        KEY_N[2] = 1'b1;
        idle(1);
        KEY_N[2] = 1'b0;
        push(cyc + 7, 4'b0100, 4'b0000, 4'b0000);
        idle(10);
        KEY_N[2] = 1'b1;
        push(cyc + 7, 4'b0000, 4'b0100, 4'b0000);
        idle(12);

        // key3 short hold
        KEY_N[3] = 1'b0;
        push(cyc + 7, 4'b1000, 4'b0000, 4'b0000);
        idle(12);
        KEY_N[3] = 1'b1;
        push(cyc + 7, 4'b0000, 4'b1000, 4'b0000);
        idle(12);

        // keys 0 and 2 together, then reset mid-press
        KEY_N = 4'b1010;
        push(cyc + 7, 4'b0101, 4'b0000, 4'b0000);
        idle(9);
        #1 RST_N = 1'b0;
        idle(3);
        RST_N = 1'b1;
        push(cyc + 7, 4'b0101, 4'b0000, 4'b0000);
        idle(6);
        KEY_N = 4'b1111;
        push(cyc + 7, 4'b0000, 4'b0101, 4'b0000);
        idle(12);

        // short release bounce restarts the long timer
        KEY_N[0] = 1'b0;
        c = cyc;
        push(c + 7, 4'b0001, 4'b0000, 4'b0000);
        idle(10);
        KEY_N[0] = 1'b1;
        idle(2);
        KEY_N[0] = 1'b0;
        push(c + 35, 4'b0000, 4'b0000, 4'b0001);
        idle(28);
        KEY_N[0] = 1'b1;
        push(cyc + 7, 4'b0000, 4'b0001, 4'b0000);
        idle(12);

        nchk++;
        assert (q.size() == 0) npass++;
        else begin
            nfail++;
            $error("FAIL pending observed=%0d expected=0", q.size());
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
